// File: rtl/jtag_user_pkg.sv
// Shared constants and state types for user-JTAG data register blocks.
// Field positions are common to the capture word and the update word.
package jtag_user_pkg;

  localparam logic [7:0] USER_IR_BRIDGE = 8'h56;

  // Capture word layout
  localparam int unsigned RSP_VALID_BIT = 0;
  localparam int unsigned CMD_BUSY_BIT  = 1;
  localparam int unsigned PAYLOAD_LSB   = 2;

  // Update word layout
  localparam int unsigned RSP_ACK_BIT = 0;
  localparam int unsigned CMD_EN_BIT  = 1;

  typedef enum logic {
    CMD_EMPTY,
    CMD_PENDING
  } cmd_state_e;

  typedef enum logic {
    RSP_EMPTY,
    RSP_FULL
  } rsp_state_e;

endpackage

// File: rtl/jtag_strobe_sync.sv
// Two-flop synchroniser bank for the user-JTAG strobes plus a UDRCK
// rising-edge detector; all outputs are in the fabric clock domain.
module jtag_strobe_sync (
  input  logic clk,
  input  logic rst,
  input  logic udrck,
  input  logic udrcap,
  input  logic udrsh,
  input  logic udrupd,
  input  logic urstb,
  input  logic utdi,
  output logic udrcap_s,
  output logic udrsh_s,
  output logic udrupd_s,
  output logic urstb_s,
  output logic utdi_s,
  output logic udrck_rise
);

  logic [5:0] meta;
  logic [5:0] sync;
  logic       udrck_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta    <= '0;
      sync    <= '0;
      udrck_d <= 1'b0;
    end else begin
      meta    <= {udrck, udrcap, udrsh, udrupd, urstb, utdi};
      sync    <= meta;
      udrck_d <= sync[5];
    end
  end

  assign udrcap_s   = sync[4];
  assign udrsh_s    = sync[3];
  assign udrupd_s   = sync[2];
  assign urstb_s    = sync[1];
  assign utdi_s     = sync[0];
  assign udrck_rise = sync[5] & ~udrck_d;

endmodule

// File: rtl/jtag_user_dr_bridge.sv
// User data register behind the debug core's user-JTAG port; turns DR
// updates into a valid/ready command stream and returns responses on capture.
module jtag_user_dr_bridge
  import jtag_user_pkg::*;
#(
  parameter logic [7:0]  IR_CODE = USER_IR_BRIDGE,
  parameter int unsigned DATA_W  = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              UDRCK,
  input  logic              UDRCAP,
  input  logic              UDRSH,
  input  logic              UDRUPD,
  input  logic [7:0]        UIREG,
  input  logic              URSTB,
  input  logic              UTDI,
  output logic              UTDO,
  output logic              UTDODRV,
  output logic [DATA_W-1:0] CMD_DATA,
  output logic              CMD_VALID,
  input  logic              CMD_READY,
  input  logic [DATA_W-1:0] RSP_DATA,
  input  logic              RSP_VALID,
  output logic              RSP_READY,
  output logic              OVERRUN
);

  localparam int unsigned SR_W = DATA_W + 2;

  logic              udrcap_s, udrsh_s, udrupd_s, urstb_s, utdi_s, udrck_rise;
  logic [7:0]        uireg_q;
  logic [SR_W-1:0]   sr;
  logic [DATA_W-1:0] rsp_hold_data;
  logic              rsp_hold_valid;
  cmd_state_e        cmd_state;
  rsp_state_e        rsp_state;
  logic              sel, dr_act, do_update, cmd_en, rsp_ack;

  jtag_strobe_sync u_sync (
    .clk        (CLK),
    .rst        (RST),
    .udrck      (UDRCK),
    .udrcap     (UDRCAP),
    .udrsh      (UDRSH),
    .udrupd     (UDRUPD),
    .urstb      (URSTB),
    .utdi       (UTDI),
    .udrcap_s   (udrcap_s),
    .udrsh_s    (udrsh_s),
    .udrupd_s   (udrupd_s),
    .urstb_s    (urstb_s),
    .utdi_s     (utdi_s),
    .udrck_rise (udrck_rise)
  );

  // TAP reset masks every strobe, so update side effects share one gate
  assign sel            = (uireg_q == IR_CODE);
  assign dr_act         = udrck_rise && sel && urstb_s;
  assign do_update      = dr_act && !udrcap_s && !udrsh_s && udrupd_s;
  assign cmd_en         = do_update && sr[CMD_EN_BIT];
  assign rsp_ack        = do_update && sr[RSP_ACK_BIT];
  assign rsp_hold_valid = (rsp_state == RSP_FULL);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      uireg_q <= '0;
      UTDODRV <= 1'b0;
    end else begin
      uireg_q <= UIREG;
      UTDODRV <= sel;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sr      <= '0;
      UTDO    <= 1'b0;
      OVERRUN <= 1'b0;
    end else if (!urstb_s) begin
      sr      <= '0;
      UTDO    <= 1'b0;
      OVERRUN <= 1'b0;
    end else if (dr_act) begin
      if (udrcap_s) begin
        sr   <= {rsp_hold_data, CMD_VALID, rsp_hold_valid};
        UTDO <= rsp_hold_valid;
      end else if (udrsh_s) begin
        sr   <= {utdi_s, sr[SR_W-1:1]};
        UTDO <= sr[1];
      end else if (cmd_en && cmd_state == CMD_PENDING) begin
        OVERRUN <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cmd_state <= CMD_EMPTY;
      CMD_VALID <= 1'b0;
      CMD_DATA  <= '0;
    end else begin
      case (cmd_state)
        CMD_EMPTY: if (cmd_en) begin
          cmd_state <= CMD_PENDING;
          CMD_VALID <= 1'b1;
          CMD_DATA  <= sr[SR_W-1:PAYLOAD_LSB];
        end
        CMD_PENDING: if (CMD_READY) begin
          cmd_state <= CMD_EMPTY;
          CMD_VALID <= 1'b0;
        end
        default: cmd_state <= CMD_EMPTY;
      endcase
    end
  end

  // An ack arriving while full wins; the offered word waits for RSP_READY
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rsp_state     <= RSP_EMPTY;
      rsp_hold_data <= '0;
      RSP_READY     <= 1'b1;
    end else begin
      case (rsp_state)
        RSP_EMPTY: if (RSP_VALID) begin
          rsp_state     <= RSP_FULL;
          rsp_hold_data <= RSP_DATA;
          RSP_READY     <= 1'b0;
        end
        RSP_FULL: if (rsp_ack) begin
          rsp_state <= RSP_EMPTY;
          RSP_READY <= 1'b1;
        end
        default: rsp_state <= RSP_EMPTY;
      endcase
    end
  end

endmodule
